// File: rtl/array_26_arbiter.sv
// Front-end for the 4096 x 112 single-port array: zero-fill, then
// round-robin sharing of the RW port between requesters A and B.
module array_26_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int LANES   = 16,
  parameter int LANE_W  = 7,
  parameter int INIT_EN = 1,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              init_done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wmode,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [LANES-1:0]  a_wmask,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wmode,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LANES-1:0]  b_wmask,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    START,
    INIT,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_prio;
  logic              rd_owner_a;
  logic              rd_owner_b;

  logic in_init;
  logic can_gnt;
  logic gnt_a;
  logic gnt_b;

  assign in_init = (state == INIT);
  assign can_gnt = (state == RUN) && !init_req;

  // A wins unless B is also valid and B holds the priority
  assign gnt_a = can_gnt && a_valid &&
                 (!b_valid || !rr_prio);
  assign gnt_b = can_gnt && b_valid &&
                 (!a_valid || rr_prio);

  assign init_done = (state == RUN);
  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;
  assign a_rvalid  = rd_owner_a;
  assign b_rvalid  = rd_owner_b;
  assign a_rdata   = mem_rdata;
  assign b_rdata   = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    unique case (1'b1)
      in_init: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = init_cnt;
        mem_wmask = '1;
      end
      gnt_a: begin
        mem_en    = 1'b1;
        mem_wmode = a_wmode;
        mem_addr  = a_addr;
        mem_wmask = a_wmask;
        mem_wdata = a_wdata;
      end
      gnt_b: begin
        mem_en    = 1'b1;
        mem_wmode = b_wmode;
        mem_addr  = b_addr;
        mem_wmask = b_wmask;
        mem_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= START;
      init_cnt   <= '0;
      rr_prio    <= 1'b0;
      rd_owner_a <= 1'b0;
      rd_owner_b <= 1'b0;
    end else begin
      unique case (state)
        START: begin
          init_cnt <= '0;
          state    <= (INIT_EN != 0) ? INIT : RUN;
        end
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) state <= RUN;
        end
        RUN: begin
          if (init_req) state <= START;
        end
        default: state <= START;
      endcase
      if (gnt_a)      rr_prio <= 1'b1;
      else if (gnt_b) rr_prio <= 1'b0;
      rd_owner_a <= gnt_a && !a_wmode;
      rd_owner_b <= gnt_b && !b_wmode;
    end
  end

endmodule

// File: tb/tb_array_26_arbiter.sv
// Bench for array_26_arbiter: behavioural array model, vector table
// for arbitration, and hand sequences for zero-fill/init_req/reset.
module tb_array_26_arbiter;

  localparam int AW = 12;
  localparam int LN = 16;
  localparam int DW = 112;

  logic          clock;
  logic          reset_n;
  logic          init_req;
  logic          init_done;
  logic          a_valid, a_ready, a_wmode, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [LN-1:0] a_wmask;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_wmode, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [LN-1:0] b_wmask;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_en, mem_wmode;
  logic [AW-1:0] mem_addr;
  logic [LN-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  array_26_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .init_req(init_req), .init_done(init_done),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_wmode(a_wmode), .a_addr(a_addr),
    .a_wmask(a_wmask), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_wmode(b_wmode), .b_addr(b_addr),
    .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // array model: lane-masked write, 1-cycle registered read
  logic [DW-1:0] mem [4096];
  initial begin
    logic [127:0] t;
    for (int i = 0; i < 4096; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = t[DW-1:0];
    end
    mem_rdata = '0;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int l = 0; l < LN; l++)
          if (mem_wmask[l])
            mem[mem_addr][l*7 +: 7] <= mem_wdata[l*7 +: 7];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          v, w;
    logic [AW-1:0] addr;
    logic [LN-1:0] mask;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    cmd_t          a, b;
    logic          ar, br, en, wm;
    logic [AW-1:0] addr;
    logic          arv, brv, crd;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic cmd_t idle();
    cmd_t c;
    c.v = 0; c.w = 0; c.addr = '0;
    c.mask = '0; c.data = '0;
    return c;
  endfunction

  function automatic cmd_t rd(input logic [AW-1:0] ad);
    cmd_t c;
    c = idle();
    c.v = 1; c.addr = ad;
    return c;
  endfunction

  function automatic cmd_t wr(input logic [AW-1:0] ad,
                              input logic [LN-1:0] m,
                              input logic [DW-1:0] d);
    cmd_t c;
    c.v = 1; c.w = 1; c.addr = ad;
    c.mask = m; c.data = d;
    return c;
  endfunction

  function automatic vec_t mk(
      input cmd_t a, input cmd_t b,
      input logic ar, input logic br,
      input logic en, input logic wm,
      input logic [AW-1:0] ad,
      input logic arv, input logic brv,
      input logic crd, input logic [DW-1:0] r);
    vec_t v;
    v.a = a; v.b = b; v.ar = ar; v.br = br;
    v.en = en; v.wm = wm; v.addr = ad;
    v.arv = arv; v.brv = brv; v.crd = crd; v.rd = r;
    return v;
  endfunction

  task automatic drive(input cmd_t a, input cmd_t b);
    a_valid = a.v; a_wmode = a.w; a_addr = a.addr;
    a_wmask = a.mask; a_wdata = a.data;
    b_valid = b.v; b_wmode = b.w; b_addr = b.addr;
    b_wmask = b.mask; b_wdata = b.data;
  endtask

  // n zero-fill cycles from address 0, valids held high
  task automatic init_walk(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
      if (!(mem_en && mem_wmode &&
            mem_addr == AW'(i) &&
            mem_wmask == '1 && mem_wdata == '0 &&
            !a_ready && !b_ready && !init_done))
        bad++;
    end
    chk(tag, DW'(bad), '0);
  endtask

  task automatic done_chk(input string tag);
    @(negedge clock);
    drive(idle(), idle());
    #1;
    chk1({tag, "_done"}, init_done, 1'b1);
    chk1({tag, "_en"}, mem_en, 1'b0);
  endtask

  vec_t vt [13];

  initial begin
    cmd_t c0;
    c0 = idle();
    vt[0]  = mk(wr(12'h07A, 16'hFFFF, 112'h123), c0,
                1, 0, 1, 1, 12'h07A, 0, 0, 0, '0);
    vt[1]  = mk(rd(12'h07A), c0,
                1, 0, 1, 0, 12'h07A, 0, 0, 0, '0);
    vt[2]  = mk(c0, c0,
                0, 0, 0, 0, 12'h000, 1, 0, 1, 112'h123);
    vt[3]  = mk(c0, rd(12'h07A),
                0, 1, 1, 0, 12'h07A, 0, 0, 0, '0);
    vt[4]  = mk(rd(12'h010), rd(12'h020),
                1, 0, 1, 0, 12'h010, 0, 1, 1, 112'h123);
    vt[5]  = mk(rd(12'h010), rd(12'h020),
                0, 1, 1, 0, 12'h020, 1, 0, 1, '0);
    vt[6]  = mk(rd(12'h010), rd(12'h020),
                1, 0, 1, 0, 12'h010, 0, 1, 1, '0);
    vt[7]  = mk(rd(12'h010), rd(12'h020),
                0, 1, 1, 0, 12'h020, 1, 0, 1, '0);
    vt[8]  = mk(c0, rd(12'h020),
                0, 1, 1, 0, 12'h020, 0, 1, 1, '0);
    vt[9]  = mk(c0, rd(12'h020),
                0, 1, 1, 0, 12'h020, 0, 1, 1, '0);
    vt[10] = mk(c0, wr(12'h005, 16'h0001, '1),
                0, 1, 1, 1, 12'h005, 0, 1, 1, '0);
    vt[11] = mk(c0, rd(12'h005),
                0, 1, 1, 0, 12'h005, 0, 0, 0, '0);
    vt[12] = mk(c0, c0,
                0, 0, 0, 0, 12'h000, 0, 1, 1, 112'h7F);

    reset_n  = 1'b0;
    init_req = 1'b0;
    drive(rd(12'h0), rd(12'h1));
    #1;
    chk1("rst_done", init_done, 1'b0);
    chk1("rst_en", mem_en, 1'b0);
    chk1("rst_ar", a_ready, 1'b0);
    chk1("rst_br", b_ready, 1'b0);
    chk1("rst_arv", a_rvalid, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk1("start_en", mem_en, 1'b0);
    chk1("start_ar", a_ready, 1'b0);
    init_walk("init0", 4096);
    done_chk("init0");

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive(vt[i].a, vt[i].b);
      #1;
      chk1($sformatf("v%0d_ar", i), a_ready, vt[i].ar);
      chk1($sformatf("v%0d_br", i), b_ready, vt[i].br);
      chk1($sformatf("v%0d_en", i), mem_en, vt[i].en);
      chk1($sformatf("v%0d_wm", i), mem_wmode, vt[i].wm);
      chk($sformatf("v%0d_addr", i),
          DW'(mem_addr), DW'(vt[i].addr));
      chk1($sformatf("v%0d_arv", i), a_rvalid, vt[i].arv);
      chk1($sformatf("v%0d_brv", i), b_rvalid, vt[i].brv);
      if (vt[i].crd)
        chk($sformatf("v%0d_rd", i), a_rdata, vt[i].rd);
    end

    // read granted just before an init_req pulse still returns
    @(negedge clock);
    drive(rd(12'h005), idle());
    #1;
    chk1("pre_ar", a_ready, 1'b1);
    @(negedge clock);
    drive(rd(12'h07A), idle());
    init_req = 1'b1;
    #1;
    chk1("ireq_ar", a_ready, 1'b0);
    chk1("ireq_en", mem_en, 1'b0);
    chk1("ireq_arv", a_rvalid, 1'b1);
    chk("ireq_rd", a_rdata, 112'h7F);
    @(negedge clock);
    init_req = 1'b0;
    #1;
    chk1("ireq_start_done", init_done, 1'b0);
    chk1("ireq_start_en", mem_en, 1'b0);
    chk1("ireq_start_arv", a_rvalid, 1'b0);
    chk1("ireq_start_ar", a_ready, 1'b0);
    init_walk("init1", 4096);
    done_chk("init1");

    @(negedge clock);
    drive(rd(12'h07A), idle());
    #1;
    chk1("rezero_ar", a_ready, 1'b1);
    @(negedge clock);
    drive(idle(), idle());
    #1;
    chk1("rezero_arv", a_rvalid, 1'b1);
    chk("rezero_rd", a_rdata, '0);

    // reset mid zero-fill at init_cnt = 1000
    @(negedge clock);
    init_req = 1'b1;
    @(negedge clock);
    init_req = 1'b0;
    drive(rd(12'h0), rd(12'h1));
    #1;
    chk1("mid_start_en", mem_en, 1'b0);
    init_walk("init2a", 1000);
    @(negedge clock);
    #1;
    chk1("mid_en", mem_en, 1'b1);
    chk("mid_addr", DW'(mem_addr), DW'(1000));
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_en", mem_en, 1'b0);
    chk1("mid_rst_done", init_done, 1'b0);
    chk1("mid_rst_ar", a_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk1("mid_rel_en", mem_en, 1'b0);
    init_walk("init2b", 4096);
    done_chk("init2b");

    @(negedge clock);
    drive(idle(), rd(12'h3E8));
    #1;
    chk1("post_br", b_ready, 1'b1);
    @(negedge clock);
    drive(idle(), idle());
    #1;
    chk1("post_brv", b_rvalid, 1'b1);
    chk("post_rd", b_rdata, '0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/array_26_arbiter.md
Name: array_26_arbiter

Overview:
- Front-end controller for the 4096 x 112-bit single-port array (16 write lanes of 7 bits, 1-cycle registered read).
- After reset, and on demand, it zero-initialises the whole array.
- It then shares the single RW port between two requesters, A (refill/write side) and B (lookup side), using round-robin arbitration.
- It routes each read response back to the requester that issued the read.

Parameters:
- ADDR_W, 12, address width; array depth is 2^ADDR_W.
- LANES, 16, number of write-mask lanes.
- LANE_W, 7, bits per lane; DATA_W = LANES*LANE_W = 112.
- INIT_EN, 1, 1 = zero-fill after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse: re-run zero-fill. Sampled only in RUN.
- init_done  out  1  high in RUN only.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  A command accepted this cycle.
- a_wmode  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wmask  in  LANES  A lane mask.
- a_wdata  in  DATA_W  A write data.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_valid, b_ready, b_wmode, b_addr, b_wmask, b_wdata, b_rvalid, b_rdata: same as A, for requester B.
- mem_en  out  1  to array RW0_en.
- mem_wmode  out  1  to RW0_wmode.
- mem_addr  out  ADDR_W  to RW0_addr.
- mem_wmask  out  LANES  to RW0_wmask.
- mem_wdata  out  DATA_W  to RW0_wdata.
- mem_rdata  in  DATA_W  from RW0_rdata.

Behaviour:
- Registers:
  - state in {START, INIT, RUN}.
  - init_cnt[ADDR_W-1:0].
  - rr_prio: 0 = A favoured, 1 = B favoured.
  - rd_owner_a, rd_owner_b: 1-bit read-return flags.
- Async reset values: state=START, init_cnt=0, rr_prio=0, rd_owner_a=0, rd_owner_b=0.
- All outputs are low while in START. This includes init_done, a_ready, b_ready, mem_en, a_rvalid and b_rvalid.
- START: no memory activity. Next edge goes to INIT if INIT_EN=1, otherwise to RUN.
- INIT:
  - Drives mem_en=1, mem_wmode=1, mem_addr=init_cnt, mem_wmask=all ones, mem_wdata=0.
  - init_cnt increments each cycle.
  - When init_cnt = 2^ADDR_W-1, the next state is RUN and init_cnt wraps to 0.
  - This is exactly 2^ADDR_W write cycles; a_ready = b_ready = 0 throughout.
- RUN, grant (combinational, same cycle as valid):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant A if rr_prio=0, otherwise grant B.
  - The granted requester sees ready=1. mem_* mirror its command, with mem_en=1.
  - No valid: mem_en=0 and the other mem_* outputs are 0.
- rr_prio update: after a grant to A, rr_prio<=1; after a grant to B, rr_prio<=0. Otherwise it holds.
- Read return:
  - rd_owner_a <= (A granted with a_wmode=0); rd_owner_b likewise for B.
  - a_rvalid = rd_owner_a and b_rvalid = rd_owner_b, i.e. 1-cycle latency after the grant.
  - a_rdata = b_rdata = mem_rdata, unconditionally. Each requester qualifies the data with its own rvalid.
- Write commands produce no response.
- Throughput: 1 command per cycle. Back-to-back reads are legal.
- init_req in RUN:
  - Blocks any grant in that cycle, so both readies are 0.
  - Next state is START. A read granted in the previous cycle still returns its rvalid normally.
  - init_req in START or INIT is ignored.
- Reset asserted mid-INIT or mid-RUN immediately clears all registers. A fresh zero-fill starts from address 0 after release, and pending rvalids are dropped.
- Requester commands must be held stable while valid is high and ready is low.

Test Plan:
- Reset release with INIT_EN=1:
  - Cycle 1 is START with mem_en=0.
  - The next 4096 cycles write addr 0..4095 with wdata=0 and wmask=0xFFFF.
  - init_done rises on the following cycle; a_ready stays 0 throughout.
- Single read, RUN:
  - Precondition: A wrote 0x123 with full mask at addr 0x7A.
  - A reads 0x7A -> a_ready=1 same cycle, mem_addr=0x7A, mem_wmode=0.
  - Next cycle a_rvalid=1, b_rvalid=0, a_rdata=the 112-bit value with low bits 0x123.
- Both valid, held continuously for 4 cycles:
  - Grants must be A, B, A, B with rr_prio starting at 0.
  - Then drop A -> B is granted every cycle.
- Partial write:
  - B writes all-ones data with wmask=0x0001 to addr 5, then reads addr 5.
  - Required: b_rdata = 0x7F, i.e. only lane 0 set and all other bits 0 from the zero-fill.
- init_req pulse in RUN while A is valid:
  - That cycle a_ready=0.
  - Then START, 4096 INIT writes, and init_done reasserts.
  - A read granted the cycle before the pulse still returns a_rvalid.
- reset_n asserted at init_cnt=1000:
  - Outputs go low immediately.
  - After release, zero-fill restarts at addr 0 and completes all 4096 writes.
